gsim_xout: RTL

Result drain for the Gauss-Seidel solver core. Collects the 16 solved unknowns x0..x15, written back by index from the compute datapath, into a local register file. On `start`, streams them out in index order over a valid/ready handshake. It sits at the opposite end of the datapath from the 16-entry rotating operand store: that store feeds the compute pipeline, and this block drains it.

---
 rtl/gsim_xout.sv | 98 +++++++++
 1 files changed

// File: rtl/gsim_xout.sv
// gsim_xout: result drain, collects x0..x15 by index and streams them in order.
// Option GSIM_XOUT_CLR_EN: each accepted beat clears its entry and written flag.
module gsim_xout #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [3:0]           wr_idx,
  input  logic [BIT_WIDTH-1:0] wr_data,
  input  logic                 start,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic [3:0]           out_idx,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 full,
  output logic                 wr_drop
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [BIT_WIDTH-1:0] mem [16];
  logic [15:0]          written;
  logic [3:0]           ptr;
  logic                 wr_drop_q;
  logic                 idle;
  logic                 hs;
  logic                 at_end;

  assign idle   = (state_q == S_IDLE);
  assign hs     = (state_q == S_STREAM) && out_ready;
  assign at_end = (ptr == 4'd15);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_STREAM;
      S_STREAM: if (hs && at_end) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr       <= 4'd0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_drop_q <= wr_en && !idle;
      case (state_q)
        S_IDLE:   if (start) ptr <= 4'd0;
        S_STREAM: if (hs && !at_end) ptr <= ptr + 4'd1;
        S_DONE:   ptr <= 4'd0;
        default:  ptr <= 4'd0;
      endcase
    end
  end

  // Writes only land while idle; the stream never sees a moving target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      written <= '0;
    end else begin
      if (idle && wr_en) begin
        mem[wr_idx]     <= wr_data;
        written[wr_idx] <= 1'b1;
      end
`ifdef GSIM_XOUT_CLR_EN
      if (hs) begin
        mem[ptr]     <= '0;
        written[ptr] <= 1'b0;
      end
`endif
    end
  end

  assign out_valid = (state_q == S_STREAM);
  assign out_data  = mem[ptr];
  assign out_idx   = ptr;
  assign out_last  = out_valid && at_end;
  assign busy      = !idle;
  assign done      = (state_q == S_DONE);
  assign full      = &written;
  assign wr_drop   = wr_drop_q;

endmodule
